// File: rtl/alu_unit.sv
// Integer execution unit for the out-of-order core: combinational RV32I compute feeding a
// small result FIFO that drains onto the common data bus when the arbiter grants the slot.

`ifndef OpBus
`define OpBus 5:0
`endif
`ifndef ROBBus
`define ROBBus 3:0
`endif

module alu_unit #(
    parameter int unsigned QDEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            clr,
    input  logic            ALU_S,
    input  logic [`OpBus]   ALU_Op,
    input  logic [31:0]     ALU_Vj,
    input  logic [31:0]     ALU_Vk,
    input  logic [31:0]     ALU_A,
    input  logic [31:0]     ALU_pc,
    input  logic [`ROBBus]  ALU_Reorder,
    output logic            ALU_full,
    input  logic            CDB_grant,
    output logic            CDB_ALU_S,
    output logic [`ROBBus]  CDB_ALU_Reorder,
    output logic [31:0]     CDB_ALU_Value,
    output logic            CDB_ALU_Jump,
    output logic [31:0]     CDB_ALU_Target
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    localparam logic [`OpBus] OpLui   = 6'd0;
    localparam logic [`OpBus] OpAuipc = 6'd1;
    localparam logic [`OpBus] OpJal   = 6'd2;
    localparam logic [`OpBus] OpJalr  = 6'd3;
    localparam logic [`OpBus] OpBeq   = 6'd4;
    localparam logic [`OpBus] OpBne   = 6'd5;
    localparam logic [`OpBus] OpBlt   = 6'd6;
    localparam logic [`OpBus] OpBge   = 6'd7;
    localparam logic [`OpBus] OpBltu  = 6'd8;
    localparam logic [`OpBus] OpBgeu  = 6'd9;
    localparam logic [`OpBus] OpAddi  = 6'd10;
    localparam logic [`OpBus] OpSlti  = 6'd11;
    localparam logic [`OpBus] OpSltiu = 6'd12;
    localparam logic [`OpBus] OpXori  = 6'd13;
    localparam logic [`OpBus] OpOri   = 6'd14;
    localparam logic [`OpBus] OpAndi  = 6'd15;
    localparam logic [`OpBus] OpSlli  = 6'd16;
    localparam logic [`OpBus] OpSrli  = 6'd17;
    localparam logic [`OpBus] OpSrai  = 6'd18;
    localparam logic [`OpBus] OpAdd   = 6'd19;
    localparam logic [`OpBus] OpSub   = 6'd20;
    localparam logic [`OpBus] OpSll   = 6'd21;
    localparam logic [`OpBus] OpSlt   = 6'd22;
    localparam logic [`OpBus] OpSltu  = 6'd23;
    localparam logic [`OpBus] OpXor   = 6'd24;
    localparam logic [`OpBus] OpSrl   = 6'd25;
    localparam logic [`OpBus] OpSra   = 6'd26;
    localparam logic [`OpBus] OpOr    = 6'd27;
    localparam logic [`OpBus] OpAnd   = 6'd28;

    // Compute path
    logic [31:0] res_value;
    logic        res_jump;
    logic [31:0] res_target;
    logic [31:0] jalr_sum;
    logic [31:0] br_target;
    logic [4:0]  shamt_i;
    logic [4:0]  shamt_r;

    assign jalr_sum  = ALU_Vj + ALU_A;
    assign br_target = ALU_pc + ALU_A;
    assign shamt_i   = ALU_A[4:0];
    assign shamt_r   = ALU_Vk[4:0];

    always_comb begin
        res_value  = '0;
        res_jump   = 1'b0;
        res_target = '0;
        case (ALU_Op)
            OpLui:   res_value = ALU_A;
            OpAuipc: res_value = ALU_pc + ALU_A;
            OpJal:   res_value = ALU_pc + 32'd4;
            OpJalr: begin
                res_value  = ALU_pc + 32'd4;
                res_jump   = 1'b1;
                res_target = {jalr_sum[31:1], 1'b0};
            end
            OpBeq: begin
                res_jump   = (ALU_Vj == ALU_Vk);
                res_target = br_target;
            end
            OpBne: begin
                res_jump   = (ALU_Vj != ALU_Vk);
                res_target = br_target;
            end
            OpBlt: begin
                res_jump   = ($signed(ALU_Vj) < $signed(ALU_Vk));
                res_target = br_target;
            end
            OpBge: begin
                res_jump   = ($signed(ALU_Vj) >= $signed(ALU_Vk));
                res_target = br_target;
            end
            OpBltu: begin
                res_jump   = (ALU_Vj < ALU_Vk);
                res_target = br_target;
            end
            OpBgeu: begin
                res_jump   = (ALU_Vj >= ALU_Vk);
                res_target = br_target;
            end
            OpAddi:  res_value = ALU_Vj + ALU_A;
            OpSlti:  res_value = {31'b0, $signed(ALU_Vj) < $signed(ALU_A)};
            OpSltiu: res_value = {31'b0, ALU_Vj < ALU_A};
            OpXori:  res_value = ALU_Vj ^ ALU_A;
            OpOri:   res_value = ALU_Vj | ALU_A;
            OpAndi:  res_value = ALU_Vj & ALU_A;
            OpSlli:  res_value = ALU_Vj << shamt_i;
            OpSrli:  res_value = ALU_Vj >> shamt_i;
            OpSrai:  res_value = $unsigned($signed(ALU_Vj) >>> shamt_i);
            OpAdd:   res_value = ALU_Vj + ALU_Vk;
            OpSub:   res_value = ALU_Vj - ALU_Vk;
            OpSll:   res_value = ALU_Vj << shamt_r;
            OpSlt:   res_value = {31'b0, $signed(ALU_Vj) < $signed(ALU_Vk)};
            OpSltu:  res_value = {31'b0, ALU_Vj < ALU_Vk};
            OpXor:   res_value = ALU_Vj ^ ALU_Vk;
            OpSrl:   res_value = ALU_Vj >> shamt_r;
            OpSra:   res_value = $unsigned($signed(ALU_Vj) >>> shamt_r);
            OpOr:    res_value = ALU_Vj | ALU_Vk;
            OpAnd:   res_value = ALU_Vj & ALU_Vk;
            default: ;
        endcase
    end

    // Result FIFO
    logic [`ROBBus]  reorder_q [QDEPTH];
    logic [31:0]     value_q   [QDEPTH];
    logic            jump_q    [QDEPTH];
    logic [31:0]     target_q  [QDEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push;
    logic            pop;
    logic            full_now;
    logic            wr_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(QDEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign push     = rdy & ~clr & ALU_S;
    assign full_now = (count_q == CntW'(QDEPTH));
    assign CDB_ALU_S = (count_q != '0) & CDB_grant & rdy & ~clr;
    assign pop      = CDB_ALU_S;
    // A full queue accepts a push only when the head leaves on the same edge
    assign wr_en    = push & (~full_now | pop);
    assign ALU_full = full_now | ((count_q == CntW'(QDEPTH - 1)) & ALU_S);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                reorder_q[i] <= '0;
                value_q[i]   <= '0;
                jump_q[i]    <= 1'b0;
                target_q[i]  <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                reorder_q[wr_ptr_q] <= ALU_Reorder;
                value_q[wr_ptr_q]   <= res_value;
                jump_q[wr_ptr_q]    <= res_jump;
                target_q[wr_ptr_q]  <= res_target;
            end
        end
    end

    assign CDB_ALU_Reorder = reorder_q[rd_ptr_q];
    assign CDB_ALU_Value   = value_q[rd_ptr_q];
    assign CDB_ALU_Jump    = jump_q[rd_ptr_q];
    assign CDB_ALU_Target  = target_q[rd_ptr_q];

    alu_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && full_now));

endmodule

// File: tb/tb_alu_unit.sv
// Randomised scoreboard bench for alu_unit: expected CDB results are queued at issue and a
// negedge monitor compares them whenever the unit broadcasts.

module tb_alu_unit;

    localparam int unsigned QDEPTH = 2;

    localparam logic [5:0] OpLui = 6'd0,  OpAuipc = 6'd1,  OpJal = 6'd2,   OpJalr = 6'd3;
    localparam logic [5:0] OpBeq = 6'd4,  OpBne = 6'd5,    OpBlt = 6'd6,   OpBge = 6'd7;
    localparam logic [5:0] OpBltu = 6'd8, OpBgeu = 6'd9,   OpAddi = 6'd10, OpSlti = 6'd11;
    localparam logic [5:0] OpSltiu = 6'd12, OpXori = 6'd13, OpOri = 6'd14, OpAndi = 6'd15;
    localparam logic [5:0] OpSlli = 6'd16, OpSrli = 6'd17, OpSrai = 6'd18, OpAdd = 6'd19;
    localparam logic [5:0] OpSub = 6'd20, OpSll = 6'd21,   OpSlt = 6'd22,  OpSltu = 6'd23;
    localparam logic [5:0] OpXor = 6'd24, OpSrl = 6'd25,   OpSra = 6'd26,  OpOr = 6'd27;
    localparam logic [5:0] OpAnd = 6'd28;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, ALU_S, CDB_grant;
    logic [5:0]  ALU_Op;
    logic [31:0] ALU_Vj, ALU_Vk, ALU_A, ALU_pc;
    logic [3:0]  ALU_Reorder;
    logic        ALU_full, CDB_ALU_S, CDB_ALU_Jump;
    logic [3:0]  CDB_ALU_Reorder;
    logic [31:0] CDB_ALU_Value, CDB_ALU_Target;

    alu_unit #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .ALU_S(ALU_S), .ALU_Op(ALU_Op),
        .ALU_Vj(ALU_Vj), .ALU_Vk(ALU_Vk), .ALU_A(ALU_A), .ALU_pc(ALU_pc),
        .ALU_Reorder(ALU_Reorder), .ALU_full(ALU_full), .CDB_grant(CDB_grant),
        .CDB_ALU_S(CDB_ALU_S), .CDB_ALU_Reorder(CDB_ALU_Reorder),
        .CDB_ALU_Value(CDB_ALU_Value), .CDB_ALU_Jump(CDB_ALU_Jump),
        .CDB_ALU_Target(CDB_ALU_Target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
    } res_t;

    res_t       sb[$];
    res_t       mon_exp;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         rand_knobs = 1'b0;
    bit         mon_ev, mon_ef;
    logic [3:0] next_tag = 4'd0;

    function automatic res_t model(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                   input logic [31:0] a, input logic [31:0] pc, input logic [3:0] tag);
        res_t r;
        int sj, sk, sa;
        r = '0;
        r.tag = tag;
        sj = vj;
        sk = vk;
        sa = a;
        case (op)
            OpLui:   r.value = a;
            OpAuipc: r.value = pc + a;
            OpJal:   r.value = pc + 32'd4;
            OpJalr: begin r.value = pc + 32'd4; r.jump = 1'b1; r.target = (vj + a) & 32'hffff_fffe; end
            OpBeq:   begin r.jump = (vj == vk); r.target = pc + a; end
            OpBne:   begin r.jump = (vj != vk); r.target = pc + a; end
            OpBlt:   begin r.jump = (sj < sk);  r.target = pc + a; end
            OpBge:   begin r.jump = (sj >= sk); r.target = pc + a; end
            OpBltu:  begin r.jump = (vj < vk);  r.target = pc + a; end
            OpBgeu:  begin r.jump = (vj >= vk); r.target = pc + a; end
            OpAddi:  r.value = vj + a;
            OpSlti:  r.value = (sj < sa) ? 32'd1 : 32'd0;
            OpSltiu: r.value = (vj < a) ? 32'd1 : 32'd0;
            OpXori:  r.value = vj ^ a;
            OpOri:   r.value = vj | a;
            OpAndi:  r.value = vj & a;
            OpSlli:  r.value = vj << a[4:0];
            OpSrli:  r.value = vj >> a[4:0];
            OpSrai:  r.value = sj >>> a[4:0];
            OpAdd:   r.value = vj + vk;
            OpSub:   r.value = vj - vk;
            OpSll:   r.value = vj << vk[4:0];
            OpSlt:   r.value = (sj < sk) ? 32'd1 : 32'd0;
            OpSltu:  r.value = (vj < vk) ? 32'd1 : 32'd0;
            OpXor:   r.value = vj ^ vk;
            OpSrl:   r.value = vj >> vk[4:0];
            OpSra:   r.value = sj >>> vk[4:0];
            OpOr:    r.value = vj | vk;
            OpAnd:   r.value = vj & vk;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return $urandom_range(0, 40);
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: record what the unit accepts (or loses to a flush) on this edge.
    task automatic tick();
        @(posedge clk);
        if (rst && clr) sb.delete();
        else if (rst && rdy && ALU_S)
            sb.push_back(model(ALU_Op, ALU_Vj, ALU_Vk, ALU_A, ALU_pc, ALU_Reorder));
        #1;
        if (rand_knobs) begin
            CDB_grant = ($urandom_range(0, 3) != 0);
            rdy       = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] a, input logic [31:0] pc);
        int waited = 0;
        ALU_S = 1'b0;
        #1;
        while (ALU_full === 1'b1 && waited < 100) begin
            tick();
            ALU_S = 1'b0;
            #1;
            waited++;
        end
        n_tests++;
        if (ALU_full === 1'b1) begin
            n_fail++;
            $display("FAIL issue_wait: ALU_full still %b after %0d cycles, expected 0", ALU_full, waited);
        end else begin
            ALU_Op = op; ALU_Vj = vj; ALU_Vk = vk; ALU_A = a; ALU_pc = pc;
            ALU_Reorder = next_tag;
            ALU_S = 1'b1;
            tick();
            ALU_S = 1'b0;
            next_tag = next_tag + 4'd1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_cdb_s", 32'(CDB_ALU_S), 32'd0);
            check("rst_full", 32'(ALU_full), 32'd0);
            check("rst_head_value", CDB_ALU_Value, 32'd0);
        end else begin
            mon_ev = (sb.size() != 0) && CDB_grant && rdy && !clr;
            mon_ef = (sb.size() == int'(QDEPTH)) || ((sb.size() == int'(QDEPTH) - 1) && ALU_S);
            check("cdb_s", 32'(CDB_ALU_S), 32'(mon_ev));
            check("alu_full", 32'(ALU_full), 32'(mon_ef));
            if (mon_ev && CDB_ALU_S) begin
                mon_exp = sb.pop_front();
                check("cdb_reorder", 32'(CDB_ALU_Reorder), 32'(mon_exp.tag));
                check("cdb_value", CDB_ALU_Value, mon_exp.value);
                check("cdb_jump", 32'(CDB_ALU_Jump), 32'(mon_exp.jump));
                check("cdb_target", CDB_ALU_Target, mon_exp.target);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; rdy = 1'b1; clr = 1'b0; ALU_S = 1'b0; CDB_grant = 1'b1;
        ALU_Op = '0; ALU_Vj = '0; ALU_Vk = '0; ALU_A = '0; ALU_pc = '0; ALU_Reorder = '0;
        #23 rst = 1'b1;
        tick();

        // Single-cycle latency through an empty queue
        issue(OpAddi, 32'd5, 32'd0, 32'hffff_fffd, 32'd0);
        #1;
        check("addi_valid", 32'(CDB_ALU_S), 32'd1);
        check("addi_value", CDB_ALU_Value, 32'd2);
        check("addi_jump", 32'(CDB_ALU_Jump), 32'd0);

        issue(OpBlt, 32'hffff_ffff, 32'd1, 32'h20, 32'h100);
        #1;
        check("blt_jump", 32'(CDB_ALU_Jump), 32'd1);
        check("blt_target", CDB_ALU_Target, 32'h120);
        issue(OpBltu, 32'hffff_ffff, 32'd1, 32'h20, 32'h100);
        #1;
        check("bltu_jump", 32'(CDB_ALU_Jump), 32'd0);

        issue(OpJalr, 32'h1003, 32'd0, 32'd0, 32'h40);
        #1;
        check("jalr_value", CDB_ALU_Value, 32'h44);
        check("jalr_jump", 32'(CDB_ALU_Jump), 32'd1);
        check("jalr_target", CDB_ALU_Target, 32'h1002);
        tick();

        // Back-pressure with grant withheld, then in-order drain
        CDB_grant = 1'b0;
        issue(OpAddi, 32'd0, 32'd0, 32'd1, 32'd0);
        issue(OpAddi, 32'd0, 32'd0, 32'd2, 32'd0);
        #1;
        check("bp_full", 32'(ALU_full), 32'd1);
        CDB_grant = 1'b1;
        #1;
        check("bp_head_first", CDB_ALU_Value, 32'd1);
        issue(OpAddi, 32'd0, 32'd0, 32'd3, 32'd0);
        #1;
        check("bp_drain_valid", 32'(CDB_ALU_S), 32'd1);
        check("bp_head_third", CDB_ALU_Value, 32'd3);
        tick();

        // Flush with a concurrent issue
        CDB_grant = 1'b0;
        issue(OpAddi, 32'd0, 32'd0, 32'd9, 32'd0);
        issue(OpAddi, 32'd0, 32'd0, 32'd10, 32'd0);
        clr = 1'b1; ALU_S = 1'b1; ALU_Op = OpAddi; CDB_grant = 1'b1;
        #1;
        check("clr_cdb_s", 32'(CDB_ALU_S), 32'd0);
        tick();
        clr = 1'b0; ALU_S = 1'b0;
        #1;
        check("post_clr_cdb_s", 32'(CDB_ALU_S), 32'd0);
        check("post_clr_full", 32'(ALU_full), 32'd0);

        // Asynchronous reset with a full queue
        CDB_grant = 1'b0;
        for (int i = 0; i < int'(QDEPTH); i++) issue(OpAddi, 32'd0, 32'd0, 32'(20 + i), 32'd0);
        #1;
        check("pre_rst_full", 32'(ALU_full), 32'd1);
        CDB_grant = 1'b1;
        rst = 1'b0;
        #1;
        check("async_rst_cdb_s", 32'(CDB_ALU_S), 32'd0);
        check("async_rst_full", 32'(ALU_full), 32'd0);
        check("async_rst_value", CDB_ALU_Value, 32'd0);
        sb.delete();
        tick();
        #1 rst = 1'b1;
        issue(OpAddi, 32'd0, 32'd0, 32'd7, 32'd0);
        #1;
        check("post_rst_valid", 32'(CDB_ALU_S), 32'd1);
        check("post_rst_value", CDB_ALU_Value, 32'd7);

        // Random traffic with random grant/ready and occasional flushes
        rand_knobs = 1'b1;
        for (int k = 0; k < 400; k++) begin
            n = $urandom_range(0, 39);
            if (n == 0) begin
                clr = 1'b1;
                ALU_S = ($urandom_range(0, 1) != 0);
                tick();
                clr = 1'b0;
                ALU_S = 1'b0;
            end else if (n < 4) begin
                tick();
            end else begin
                issue(6'($urandom_range(0, 31)), pick(), pick(), pick(), pick());
            end
        end

        rand_knobs = 1'b0;
        rdy = 1'b1;
        CDB_grant = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: QDEPTH, default 2, result-queue depth (legal values 2..4).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low; clears all state immediately on assertion.
REQ-004 rdy  in  1  global ready; when low, state and queue hold.
REQ-005 clr  in  1  misprediction flush, synchronous.
REQ-006 ALU_S  in  1  issue valid from the reservation station.
REQ-007 ALU_Op  in  `OpBus  operation code.
REQ-008 ALU_Vj  in  32  source operand j.
REQ-009 ALU_Vk  in  32  source operand k.
REQ-010 ALU_A  in  32  immediate.
REQ-011 ALU_pc  in  32  instruction pc.
REQ-012 ALU_Reorder  in  `ROBBus  ROB tag.
REQ-013 ALU_full  out  1  back-pressure to the reservation station; blocks new issue.
REQ-014 CDB_grant  in  1  CDB arbiter grants the ALU slot this cycle.
REQ-015 CDB_ALU_S  out  1  broadcast valid.
REQ-016 CDB_ALU_Reorder  out  `ROBBus  tag of broadcast.
REQ-017 CDB_ALU_Value  out  32  result value.
REQ-018 CDB_ALU_Jump  out  1  control transfer taken.
REQ-019 CDB_ALU_Target  out  32  target pc, valid when Jump is 1.

Function
REQ-020 Compute is combinational from the ALU_* inputs; the result {Reorder, Value, Jump, Target} is pushed into a QDEPTH-entry FIFO at the edge ending any cycle with rst high, rdy=1, clr=0 and ALU_S=1.
REQ-021 LUI: Value=A. AUIPC: Value=pc+A. JAL: Value=pc+4, Jump=0 (resolved at decode).
REQ-022 JALR: Value=pc+4, Jump=1, Target=(Vj+A) with bit 0 cleared.
REQ-023 I-type ops (ADDI..SRAI): Vj op A; shift amount is A[4:0]; SRAI arithmetic; SLTI signed, SLTIU unsigned.
REQ-024 R-type ops (ADD..AND): Vj op Vk; shift amount is Vk[4:0]; SUB is Vj-Vk; all sums wrap mod 2^32.
REQ-025 Branches: Value=0; Jump=condition (BLT/BGE signed, BLTU/BGEU unsigned); Target=pc+A.
REQ-026 Non-branch, non-JALR ops drive Jump=0 and Target=0.
REQ-027 Any op outside REQ-021..025 pushes Value=0, Jump=0.
REQ-028 CDB_ALU_S=(count!=0)&&CDB_grant&&rdy&&!clr, combinational; the Reorder/Value/Jump/Target outputs always show the head entry.
REQ-029 Pop on the edge ending any cycle with CDB_ALU_S=1.
REQ-030 Minimum latency: issue in cycle t with the queue empty; broadcast possible in cycle t+1.
REQ-031 Simultaneous push and pop: count unchanged; FIFO order preserved; pointers wrap modulo QDEPTH.
REQ-032 ALU_full=(count==QDEPTH)||(count==QDEPTH-1&&ALU_S), combinational, accounting for the one-cycle issue latency; this guarantees no push to a full queue without a pop.
REQ-033 Push when count==QDEPTH with no pop: entry dropped, and the assertion alu_overflow fires (illegal stimulus).
REQ-034 clr=1 (rdy ignored): count and pointers cleared, the ALU_S push is discarded, CDB_ALU_S=0 that cycle.
REQ-035 rdy=0 and clr=0: no push, no pop, CDB_ALU_S=0.

Reset
REQ-036 While rst=0: count=0, pointers=0, CDB_ALU_S=0, ALU_full=0; head outputs drive 0.
REQ-037 Reset asserted mid-operation discards all queued results; the first push after release lands in entry 0.

Verification
REQ-038 ADDI Vj=5, A=-3 issued at t, grant held high -> t+1: CDB_ALU_S=1, Value=2, Jump=0.
REQ-039 BLT Vj=-1, Vk=1, pc=0x100, A=0x20 -> Jump=1, Target=0x120. Same test with BLTU -> Jump=0.
REQ-040 JALR Vj=0x1003, A=0, pc=0x40 -> Value=0x44, Jump=1, Target=0x1002.
REQ-041 Grant low, three issues paced by ALU_full (QDEPTH=2) -> ALU_full high after 2 in flight, no overflow; grant high -> results emerge in issue order, one per cycle.
REQ-042 Queue holding 2 entries, clr pulsed together with ALU_S -> next cycle count=0, CDB_ALU_S=0 despite grant.
REQ-043 rst pulled low asynchronously between edges with a full queue -> CDB_ALU_S and ALU_full drop to 0 immediately.
